// File: rtl/stopwatch_pkg.sv
// Shared state encodings for the stopwatch/watch button controller.
// The watch state codes double as the externally visible edit-field codes.
package stopwatch_pkg;

   localparam logic [1:0] FIELD_NONE = 2'd0;
   localparam logic [1:0] FIELD_SEC  = 2'd1;
   localparam logic [1:0] FIELD_MIN  = 2'd2;
   localparam logic [1:0] FIELD_HOUR = 2'd3;

   typedef enum logic [1:0] {
      SW_STOP  = 2'd0,
      SW_RUN   = 2'd1,
      SW_CLEAR = 2'd2
   } sw_state_t;

   typedef enum logic [1:0] {
      W_IDLE = FIELD_NONE,
      W_SEC  = FIELD_SEC,
      W_MIN  = FIELD_MIN,
      W_HOUR = FIELD_HOUR
   } w_state_t;

endpackage

// File: rtl/stopwatch_ctrl_btn_pulse_gen.sv
// Rising-edge pulse with hold-to-repeat: first repeat HOLD_CYCLES after the
// press, then every REPEAT_CYCLES while the button stays held.
module btn_pulse_gen #(
   parameter int unsigned HOLD_CYCLES   = 50_000_000,
   parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   input  logic i_cancel,
   output logic o_pulse
);

   logic        r_prev;
   logic        r_arm;
   logic        r_rep;
   logic [31:0] r_cnt;

   logic        w_edge;
   logic        w_due;
   logic [31:0] w_thr;

   // r_arm blocks a spurious edge from a button already held through reset
   assign w_edge  = i_btn & ~r_prev & r_arm & ~i_cancel;
   assign w_thr   = r_rep ? 32'(REPEAT_CYCLES) : 32'(HOLD_CYCLES);
   assign w_due   = i_btn & ~i_cancel & (r_cnt != 32'd0) & (r_cnt == w_thr);
   assign o_pulse = w_edge | w_due;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_prev <= 1'b0;
         r_arm  <= ~i_btn;
         r_rep  <= 1'b0;
         r_cnt  <= 32'd0;
      end else begin
         r_prev <= i_btn;
         r_arm  <= r_arm | ~i_btn;
         if (!i_btn || i_cancel) begin
            r_cnt <= 32'd0;
            r_rep <= 1'b0;
         end else if (w_edge) begin
            r_cnt <= 32'd1;
            r_rep <= 1'b0;
         end else if (w_due) begin
            r_cnt <= 32'd1;
            r_rep <= 1'b1;
         end else if (r_cnt != 32'd0 && r_cnt != '1) begin
            r_cnt <= r_cnt + 32'd1;
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Button/switch front end for a stopwatch + settable watch: run/stop/clear
// control for the stopwatch and field select with inc/dec for the watch.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES   = 50_000_000,
   parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Btn_L,
   input  logic       Btn_R,
   input  logic       Btn_U,
   input  logic       Btn_D,
   input  logic [1:0] sw,
   output logic       sw_run,
   output logic       sw_clear,
   output logic [1:0] w_field,
   output logic       w_inc,
   output logic       w_dec,
   output logic       mode,
   output logic       disp_sel,
   output logic [2:0] led
);

   sw_state_t r_sw_state;
   w_state_t  r_w_state;
   logic      r_prev_l;
   logic      r_prev_r;
   logic      r_arm_l;
   logic      r_arm_r;

   logic      w_edge_l;
   logic      w_edge_r;
   logic      w_mode_fall;
   logic      w_cancel;
   logic      w_editing;
   logic      w_pulse_u;
   logic      w_pulse_d;

   assign w_edge_l    = Btn_L & ~r_prev_l & r_arm_l;
   assign w_edge_r    = Btn_R & ~r_prev_r & r_arm_r;
   assign w_mode_fall = mode & ~sw[0];
   assign w_cancel    = (Btn_U & Btn_D) | w_mode_fall;
   assign w_editing   = sw[0] & (r_w_state != W_IDLE);
   assign w_field     = r_w_state;

   btn_pulse_gen #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_pulse_up (
      .clk      (clk),
      .reset    (reset),
      .i_btn    (Btn_U),
      .i_cancel (w_cancel),
      .o_pulse  (w_pulse_u)
   );

   btn_pulse_gen #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_pulse_dn (
      .clk      (clk),
      .reset    (reset),
      .i_btn    (Btn_D),
      .i_cancel (w_cancel),
      .o_pulse  (w_pulse_d)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_prev_l <= 1'b0;
         r_prev_r <= 1'b0;
         r_arm_l  <= ~Btn_L;
         r_arm_r  <= ~Btn_R;
      end else begin
         r_prev_l <= Btn_L;
         r_prev_r <= Btn_R;
         r_arm_l  <= r_arm_l | ~Btn_L;
         r_arm_r  <= r_arm_r | ~Btn_R;
      end
   end

   // Stopwatch keeps its state (and keeps running) while the watch is selected
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sw_state <= SW_STOP;
         sw_run     <= 1'b0;
         sw_clear   <= 1'b0;
         mode       <= 1'b0;
         disp_sel   <= 1'b0;
         led        <= 3'b001;
      end else begin
         mode     <= sw[0];
         disp_sel <= sw[1];
         led[0]   <= ~sw[0];
         led[1]   <= sw[0];
         case (r_sw_state)
            SW_STOP: begin
               if (!sw[0] && w_edge_r) begin
                  r_sw_state <= SW_RUN;
                  sw_run     <= 1'b1;
                  led[2]     <= 1'b1;
                  sw_clear   <= 1'b0;
               end else if (!sw[0] && w_edge_l) begin
                  r_sw_state <= SW_CLEAR;
                  sw_run     <= 1'b0;
                  led[2]     <= 1'b0;
                  sw_clear   <= 1'b1;
               end else begin
                  sw_run   <= 1'b0;
                  led[2]   <= 1'b0;
                  sw_clear <= 1'b0;
               end
            end
            SW_RUN: begin
               sw_clear <= 1'b0;
               if (!sw[0] && w_edge_r) begin
                  r_sw_state <= SW_STOP;
                  sw_run     <= 1'b0;
                  led[2]     <= 1'b0;
               end else begin
                  sw_run <= 1'b1;
                  led[2] <= 1'b1;
               end
            end
            default: begin
               r_sw_state <= SW_STOP;
               sw_run     <= 1'b0;
               led[2]     <= 1'b0;
               sw_clear   <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_w_state <= W_IDLE;
         w_inc     <= 1'b0;
         w_dec     <= 1'b0;
      end else begin
         w_inc <= w_editing & w_pulse_u;
         w_dec <= w_editing & w_pulse_d;
         if (!sw[0]) begin
            r_w_state <= W_IDLE;
         end else begin
            case (r_w_state)
               W_IDLE: if (w_edge_l) r_w_state <= W_SEC;
               W_SEC: begin
                  if (w_edge_r)      r_w_state <= W_IDLE;
                  else if (w_edge_l) r_w_state <= W_MIN;
               end
               W_MIN: begin
                  if (w_edge_r)      r_w_state <= W_IDLE;
                  else if (w_edge_l) r_w_state <= W_HOUR;
               end
               default: begin
                  if (w_edge_r)      r_w_state <= W_IDLE;
                  else if (w_edge_l) r_w_state <= W_SEC;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with short hold/repeat timing.
module tb_stopwatch_ctrl;

   typedef struct packed {
      logic       run;
      logic       clr;
      logic [1:0] fld;
      logic       inc;
      logic       dec;
      logic       md;
      logic       ds;
      logic [2:0] led;
   } exp_t;

   localparam logic [3:0] B0 = 4'b0000;
   localparam logic [3:0] BL = 4'b1000;
   localparam logic [3:0] BR = 4'b0100;
   localparam logic [3:0] BU = 4'b0010;
   localparam logic [3:0] BD = 4'b0001;

   logic       clk = 1'b0;
   logic       reset;
   logic       Btn_L, Btn_R, Btn_U, Btn_D;
   logic [1:0] sw;
   logic       sw_run, sw_clear, w_inc, w_dec, mode, disp_sel;
   logic [1:0] w_field;
   logic [2:0] led;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   string tag_q[$];

   stopwatch_ctrl #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .Btn_L    (Btn_L),
      .Btn_R    (Btn_R),
      .Btn_U    (Btn_U),
      .Btn_D    (Btn_D),
      .sw       (sw),
      .sw_run   (sw_run),
      .sw_clear (sw_clear),
      .w_field  (w_field),
      .w_inc    (w_inc),
      .w_dec    (w_dec),
      .mode     (mode),
      .disp_sel (disp_sel),
      .led      (led)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic exp_t mk(input logic run, input logic clr, input logic [1:0] fld,
                               input logic inc, input logic dec, input logic md, input logic ds);
      exp_t e;
      e.run = run;
      e.clr = clr;
      e.fld = fld;
      e.inc = inc;
      e.dec = dec;
      e.md  = md;
      e.ds  = ds;
      e.led = {run, md, ~md};
      return e;
   endfunction

   // drive one edge worth of inputs, queue the expectation, compare after the edge
   task automatic cyc(input logic rst_v, input logic [3:0] b, input logic [1:0] s,
                      input exp_t e, input string tag);
      exp_t  want;
      exp_t  got;
      string t;
      reset = rst_v;
      {Btn_L, Btn_R, Btn_U, Btn_D} = b;
      sw = s;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      got.run = sw_run;
      got.clr = sw_clear;
      got.fld = w_field;
      got.inc = w_inc;
      got.dec = w_dec;
      got.md  = mode;
      got.ds  = disp_sel;
      got.led = led;
      want = exp_q.pop_front();
      t    = tag_q.pop_front();
      check(t, 32'(got), 32'(want));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t idle_sw;
      idle_sw = mk(0, 0, 0, 0, 0, 0, 0);

      cyc(0, B0, 2'b00, idle_sw, "rst0");
      cyc(0, B0, 2'b00, idle_sw, "rst1");
      cyc(1, B0, 2'b00, idle_sw, "post_rst");

      cyc(1, BR, 2'b00, mk(1, 0, 0, 0, 0, 0, 0), "run_on");
      cyc(1, B0, 2'b00, mk(1, 0, 0, 0, 0, 0, 0), "run_hold");
      cyc(1, BR, 2'b00, idle_sw, "run_off");
      cyc(1, B0, 2'b00, idle_sw, "stop_hold");

      cyc(1, BL, 2'b00, mk(0, 1, 0, 0, 0, 0, 0), "clr_on");
      cyc(1, B0, 2'b00, idle_sw, "clr_off");
      cyc(1, B0, 2'b00, idle_sw, "clr_stop");
      cyc(1, BR, 2'b00, mk(1, 0, 0, 0, 0, 0, 0), "run_on2");
      cyc(1, B0, 2'b00, mk(1, 0, 0, 0, 0, 0, 0), "run_rel2");
      cyc(1, BL, 2'b00, mk(1, 0, 0, 0, 0, 0, 0), "l_in_run");
      cyc(1, B0, 2'b00, mk(1, 0, 0, 0, 0, 0, 0), "l_in_run_rel");
      cyc(1, BR, 2'b00, idle_sw, "stop2");
      cyc(1, B0, 2'b00, idle_sw, "stop2_rel");

      cyc(1, BL | BR, 2'b00, mk(1, 0, 0, 0, 0, 0, 0), "lr_tie");
      cyc(1, B0, 2'b00, mk(1, 0, 0, 0, 0, 0, 0), "lr_tie_rel");
      cyc(1, BR, 2'b00, idle_sw, "stop3");
      cyc(1, B0, 2'b00, idle_sw, "stop3_rel");

      cyc(1, B0, 2'b01, mk(0, 0, 0, 0, 0, 1, 0), "mode_w");
      for (int i = 0; i < 4; i++) begin
         logic [1:0] f;
         f = (i == 3) ? 2'd1 : 2'(i + 1);
         cyc(1, BL, 2'b01, mk(0, 0, f, 0, 0, 1, 0), "fld_press");
         cyc(1, B0, 2'b01, mk(0, 0, f, 0, 0, 1, 0), "fld_rel");
      end
      cyc(1, BR, 2'b01, mk(0, 0, 0, 0, 0, 1, 0), "fld_exit");
      cyc(1, B0, 2'b01, mk(0, 0, 0, 0, 0, 1, 0), "fld_exit_rel");

      cyc(1, BL, 2'b01, mk(0, 0, 1, 0, 0, 1, 0), "to_sec");
      cyc(1, B0, 2'b01, mk(0, 0, 1, 0, 0, 1, 0), "to_sec_rel");
      cyc(1, BL, 2'b01, mk(0, 0, 2, 0, 0, 1, 0), "to_min");
      cyc(1, B0, 2'b01, mk(0, 0, 2, 0, 0, 1, 0), "to_min_rel");
      for (int i = 0; i < 20; i++) begin
         logic p;
         p = (i == 0) || (i == 8) || (i == 12) || (i == 16);
         cyc(1, BU, 2'b01, mk(0, 0, 2, p, 0, 1, 0), "u_repeat");
      end
      cyc(1, B0, 2'b01, mk(0, 0, 2, 0, 0, 1, 0), "u_release");
      cyc(1, BD, 2'b01, mk(0, 0, 2, 0, 1, 1, 0), "dec_edit");
      cyc(1, B0, 2'b01, mk(0, 0, 2, 0, 0, 1, 0), "dec_edit_rel");
      cyc(1, BR, 2'b01, mk(0, 0, 0, 0, 0, 1, 0), "to_idle");
      cyc(1, B0, 2'b01, mk(0, 0, 0, 0, 0, 1, 0), "to_idle_rel");
      cyc(1, BD, 2'b01, mk(0, 0, 0, 0, 0, 1, 0), "dec_idle");
      cyc(1, B0, 2'b01, mk(0, 0, 0, 0, 0, 1, 0), "dec_idle_rel");
      for (int i = 0; i < 10; i++) cyc(1, BU, 2'b01, mk(0, 0, 0, 0, 0, 1, 0), "u_idle_hold");
      cyc(1, B0, 2'b01, mk(0, 0, 0, 0, 0, 1, 0), "u_idle_rel");

      cyc(1, BL, 2'b01, mk(0, 0, 1, 0, 0, 1, 0), "sec_again");
      cyc(1, B0, 2'b01, mk(0, 0, 1, 0, 0, 1, 0), "sec_again_rel");
      for (int i = 0; i < 12; i++) cyc(1, BU | BD, 2'b01, mk(0, 0, 1, 0, 0, 1, 0), "ud_both");
      for (int i = 0; i < 10; i++) cyc(1, BU, 2'b01, mk(0, 0, 1, 0, 0, 1, 0), "u_after_both");
      cyc(1, B0, 2'b01, mk(0, 0, 1, 0, 0, 1, 0), "u_after_both_rel");

      cyc(1, B0, 2'b00, idle_sw, "mode_fall_idle");
      cyc(1, BR, 2'b00, mk(1, 0, 0, 0, 0, 0, 0), "run_on3");
      cyc(1, B0, 2'b00, mk(1, 0, 0, 0, 0, 0, 0), "run_rel3");
      for (int i = 0; i < 30; i++) begin
         logic [1:0] f;
         f = (i >= 2) ? 2'd1 : 2'd0;
         cyc(1, (i == 2) ? BL : B0, 2'b01, mk(1, 0, f, 0, 0, 1, 0), "run_in_watch");
      end
      cyc(1, B0, 2'b00, mk(1, 0, 0, 0, 0, 0, 0), "back_sw");
      cyc(1, B0, 2'b10, mk(1, 0, 0, 0, 0, 0, 1), "disp_sel");
      cyc(1, B0, 2'b00, mk(1, 0, 0, 0, 0, 0, 0), "disp_sel_off");

      cyc(1, B0, 2'b01, mk(1, 0, 0, 0, 0, 1, 0), "w_again");
      cyc(1, BL, 2'b01, mk(1, 0, 1, 0, 0, 1, 0), "w_again_sec");
      cyc(1, B0, 2'b01, mk(1, 0, 1, 0, 0, 1, 0), "w_again_rel");
      for (int i = 0; i < 5; i++) cyc(1, BU | BD, 2'b01, mk(1, 0, 1, 0, 0, 1, 0), "ud_hold");
      cyc(0, BU | BD, 2'b01, idle_sw, "rst_mid_hold0");
      cyc(0, BU | BD, 2'b01, idle_sw, "rst_mid_hold1");
      cyc(1, BU | BD, 2'b01, mk(0, 0, 0, 0, 0, 1, 0), "rst_release_held");
      for (int i = 0; i < 3; i++) cyc(1, BU, 2'b01, mk(0, 0, 0, 0, 0, 1, 0), "u_held_after_rst");
      cyc(1, B0, 2'b01, mk(0, 0, 0, 0, 0, 1, 0), "u_rel_after_rst");

      cyc(1, B0, 2'b00, idle_sw, "back_sw2");
      cyc(0, BR, 2'b00, idle_sw, "rst_r_held0");
      cyc(0, BR, 2'b00, idle_sw, "rst_r_held1");
      cyc(1, BR, 2'b00, idle_sw, "r_held_at_release");
      cyc(1, BR, 2'b00, idle_sw, "r_still_held");
      cyc(1, B0, 2'b00, idle_sw, "r_released");
      cyc(1, BR, 2'b00, mk(1, 0, 0, 0, 0, 0, 0), "r_repress");
      cyc(1, B0, 2'b00, mk(1, 0, 0, 0, 0, 0, 0), "r_repress_rel");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
